// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the BCD conversion scheduler.
// Imported by the top module and the digit-adjust sub-module.
package bcd_conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  localparam int unsigned SHIFT_CYCLES = 8;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/bcd_conv_sched_digit_adj.sv
// Double-dabble digit correction: a BCD field of 5 or more gets +3
// so that the following left shift carries into the next digit.
module bcd_digit_adj
  import bcd_conv_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  assign q_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one serial binary-to-BCD engine
// between two requesters; results tagged with the owning requester.
module bcd_conv_sched
  import bcd_conv_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic [7:0] bin_a,
  input  logic       req_b,
  input  logic [7:0] bin_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic       busy,
  output logic       done,
  output logic       owner,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [1:0] hundreds
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [19:0] sr_q, sr_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        ack_a_q, ack_a_d;
  logic        ack_b_q, ack_b_d;
  logic        owner_q, owner_d;
  logic [3:0]  ones_q, ones_d;
  logic [3:0]  tens_q, tens_d;
  logic [1:0]  hund_q, hund_d;

  logic [3:0]  h_adj, t_adj, o_adj;
  logic [19:0] sr_sh;
  logic        win;

  bcd_digit_adj u_adj_h (.d_i(sr_q[19:16]), .q_o(h_adj));
  bcd_digit_adj u_adj_t (.d_i(sr_q[15:12]), .q_o(t_adj));
  bcd_digit_adj u_adj_o (.d_i(sr_q[11:8]),  .q_o(o_adj));

  assign sr_sh = {h_adj, t_adj, o_adj, sr_q[7:0]} << 1;

  // On a tie the requester that was not served last wins
  assign win = (req_a && req_b) ? ~last_q
             : (req_b ? OWNER_B : OWNER_A);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    owner_d = owner_q;
    ones_d  = ones_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    unique case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          gnt_d   = win;
          sr_d    = {12'd0, (win == OWNER_B) ? bin_b : bin_a};
          cnt_d   = '0;
          ack_a_d = (win == OWNER_A);
          ack_b_d = (win == OWNER_B);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_sh;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(SHIFT_CYCLES - 1)) begin
          state_d = DONE;
          ones_d  = sr_sh[11:8];
          tens_d  = sr_sh[15:12];
          hund_d  = sr_sh[17:16];
          owner_d = gnt_q;
          last_d  = gnt_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      gnt_q   <= OWNER_A;
      last_q  <= OWNER_B;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      owner_q <= OWNER_A;
      ones_q  <= '0;
      tens_q  <= '0;
      hund_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      owner_q <= owner_d;
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      hund_q  <= hund_d;
    end
  end

  assign ack_a    = ack_a_q;
  assign ack_b    = ack_b_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign owner    = owner_q;
  assign ones     = ones_q;
  assign tens     = tens_q;
  assign hundreds = hund_q;

endmodule

// File: doc/bcd_conv_sched.md
# bcd_conv_sched

Sequential binary-to-BCD conversion scheduler for the traffic-light LCD path. Two requesters share a single serial shift-and-add-3 (double-dabble) engine, for example the north-south and east-west countdown timers. Each requester raises a request with an 8-bit value. The block arbitrates round-robin, acknowledges the winner and runs an 8-cycle conversion. It then presents ones/tens/hundreds digits, tagged with the owner, to the LCD character formatter.

## Interface
- No parameters; input width 8 bits, output 3 BCD digits, 2 requesters (fixed).
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_a  in  1  requester A wants a conversion (level, held until ack_a)
- bin_a  in  8  requester A binary value, sampled only on grant edge
- req_b  in  1  requester B request (same rules)
- bin_b  in  8  requester B binary value
- ack_a  out  1  one-cycle pulse: A's value captured
- ack_b  out  1  one-cycle pulse: B's value captured
- busy  out  1  high in SHIFT and DONE
- done  out  1  one-cycle pulse: result registers just updated
- owner  out  1  0 = A, 1 = B; source of current result
- ones  out  4  BCD units digit
- tens  out  4  BCD tens digit
- hundreds  out  2  BCD hundreds digit (0..2)

## Operation
- States:
  - IDLE: accepts requests.
  - SHIFT: 8 conversion steps, counter 0..7.
  - DONE: one cycle, result valid.
- IDLE, no request: stay in IDLE.
- IDLE, any req high at a clock edge:
  - Grant the single requester. If both are high, grant ~last_owner.
  - Load shift register {h4, t4, o4, bin8} = {0, 0, 0, bin_x}.
  - Clear counter, assert the matching ack (registered), go to SHIFT.
- SHIFT, each cycle:
  - Every digit field >= 5 gets +3 (bcd_digit_adj on h, t, o).
  - Then the whole 20-bit register shifts left by 1.
  - On counter = 7: go to DONE. Load ones/tens/hundreds from the final o, t, h[1:0] and set owner and last_owner = granted requester.
- DONE: done = 1 for this cycle, then IDLE.
- Requests are never accepted in SHIFT or DONE. Requests arriving then wait; they are level-held, not queued.
- A req still high on return to IDLE counts as a new request. Requesters must drop req after seeing ack.
- bin_x changes after the grant edge have no effect. A req dropped before it is sampled is ignored.
- Result outputs hold their value until the next done.
- Arithmetic: the h field never exceeds 2 for 8-bit input; only h[1:0] is exported. The add-3 is applied before the shift on all 8 steps.

## Timing
- Reset (async assert, sync-released by top level):
  - State = IDLE, counter 0.
  - ack_a, ack_b, busy, done, owner = 0.
  - ones, tens, hundreds = 0.
  - last_owner = 1, so A wins the first tie.
- Grant edge E0: ack high and busy high in the cycle after E0.
- Shift edges E1..E8. DONE is entered at E8, so done is high in the cycle after E8, i.e. 8 cycles after ack.
- Digits and owner become valid in the same cycle as done.
- E9: back to IDLE, busy low. The earliest next grant is E10, so throughput is one conversion per 10 cycles.
- Reset mid-conversion: conversion abandoned, no ack or done, all outputs return to reset values. The requester must re-request.

## Structure
- Package bcd_conv_pkg holds:
  - the state enum IDLE/SHIFT/DONE;
  - SHIFT_CYCLES = 8;
  - OWNER_A = 0, OWNER_B = 1.
- One sub-module, bcd_digit_adj: 4-bit combinational "if >= 5 add 3", instantiated 3 times.
- Arbiter, counter, shift register and result registers stay in the top module.

## Test plan
- Reset check: hold rst_n low with reqs high -> all outputs 0, no ack. Release -> first grant goes to A.
- Single conversion, req_a with bin_a = 255:
  - ack_a one cycle after the sampling edge.
  - done 8 cycles after ack with hundreds = 2, tens = 5, ones = 5, owner = 0.
  - busy low the cycle after done.
- Simultaneous requests right after reset, bin_a = 7 and bin_b = 200, both held until ack:
  - A served first: 0/0/7, owner = 0.
  - B granted in the next IDLE: 2/0/0, owner = 1.
  - A following tie is granted to A.
- Digit boundaries:
  - 0 -> 0/0/0
  - 9 -> 0/0/9
  - 10 -> 0/1/0
  - 99 -> 0/9/9
  - 100 -> 1/0/0
  - 199 -> 1/9/9
  - all 0..255 swept against a reference model.
- Mid-operation reset on the 4th SHIFT cycle -> no done, outputs 0. The next request with bin_a = 42 gives 0/4/2.
- Requests while busy:
  - req_b raised during A's conversion gets no ack until IDLE, then is granted.
  - Changing bin_a after ack_a leaves A's result unchanged.
